button_scan: RTL
================

Name: button_scan

Overview:
- Front-end for the 12 game push-buttons, directly upstream of the turn, is_right and who_push stages.
- Synchronises and debounces each button, then detects clean press events.
- Serialises simultaneous presses in fixed priority order.
- Presents each press as a one-cycle key code with a valid strobe.

Parameters:
- DEB_CNT, 500000: consecutive stable cycles needed to accept a level change (10 ms at 50 MHz).
- CNT_W, 19: debounce counter width; must hold DEB_CNT-1.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- keypad_in  input  12  raw buttons, concatenated {b1..b12}: bit 11 = b1, bit 0 = b12; active-high, asynchronous to clk
- scan_out  output  4  key code of the emitted press (1..12, b1=1 .. b12=12); 0 when no event
- valid  output  1  one-cycle strobe; high exactly when scan_out is non-zero
- held  output  12  debounced level per button, same bit order as keypad_in

Behaviour:
- Reset and clock: one clock, clk. rst is asynchronous and active-high.
- Reset values: scan_out=0, valid=0, held=0. Reset also clears all synchronisers, counters, debounced states and the pending mask.
- Per key, synchroniser: 2-flop synchroniser s1 -> s2.
- Per key, debounce counter:
  - Counter increments each cycle while s2 != deb.
  - Counter clears to 0 on any cycle where s2 == deb.
  - When s2 != deb and counter == DEB_CNT-1, deb toggles on that edge and the counter clears.
- Rise event: a 0->1 toggle of deb is a rise event. It sets the key's bit in a 12-bit pending mask on the same edge that deb toggles.
- Release: a 1->0 toggle updates held only and produces no event.
- Glitches: any mismatch run shorter than DEB_CNT cycles produces no change.
- Emitter, every cycle:
  - If pending is non-zero, select the lowest key code set (b1 highest priority).
  - Register scan_out=code and valid=1, and clear that pending bit.
  - Otherwise register scan_out=0 and valid=0.
- Latency, uncontested press: edge 1 is the first edge sampling the pin high.
  - s2 goes high at edge 2.
  - deb and held go high at edge 2+DEB_CNT.
  - valid/scan_out are high for the single cycle following edge 3+DEB_CNT.
- Simultaneous rises on several keys: all are captured, then emitted on consecutive cycles in ascending code order. No press is lost.
- Rise on a bit already pending: merged into one event.
- Rise on the bit being emitted in the same cycle: the bit stays set, so a second event follows.
- Holding a key produces exactly one event, regardless of hold length.
- Reset mid-operation: outputs drop immediately (asynchronous). After reset deassertion, a still-held key is treated as a new press and emits one event after normal debounce latency.
- Width rules:
  - Counter compare is on CNT_W bits; DEB_CNT >= 2 required.
  - scan_out code = 12 - bit index.

Decomposition:
- Shared package:
  - KEY_NONE = 4'd0
  - N_KEYS = 12
  - Key code constants KEY_B1..KEY_B12 = 1..12
  - Default DEB_CNT
- Natural sub-module: debounce_cell, instantiated 12 times.
  - Contains synchroniser, counter and deb register.
  - Outputs the level (held bit) and a one-cycle rise pulse.
- Pending mask and priority emitter live in button_scan.

Test Plan (DEB_CNT=4):
- Reset: assert rst with b4 pending and mid-count -> scan_out=0, valid=0, held=0 immediately, without waiting for a clock edge; no event while rst high.
- Clean press b5 from edge 1 -> held[7]=1 after edge 6; valid=1, scan_out=5 for one cycle after edge 7; then 0.
- Bounce b3: repeated pattern high 3 cycles / low 1 cycle -> no valid, held[9]=0. Then stable high -> exactly one event with code 3.
- Simultaneous b1 and b7 rising on the same edge -> scan_out=1 then scan_out=7 on consecutive cycles, valid high for both; then idle.
- Hold b2 for 100 cycles then release -> one event (code 2) only; held[10] clears 6 edges after the pin falls; no event on release.
- Reset while b9 held, release rst -> one event, scan_out=9, after edge 7 counted from the first post-reset edge.

Source files
------------

// File: rtl/button_scan_pkg.sv
// button_scan_pkg: shared constants for the 12-button scan front-end.
//   N_KEYS       number of game push-buttons
//   KEY_*        key codes presented on scan_out (KEY_NONE = no event)
//   DEB_CNT_DEF  default debounce length in cycles (10 ms at 50 MHz)
//   CNT_W_DEF    default debounce counter width (holds DEB_CNT_DEF-1)
//   code_of()    maps a keypad bit index to its key code
package button_scan_pkg;

  localparam int N_KEYS      = 12;
  localparam int DEB_CNT_DEF = 500000;
  localparam int CNT_W_DEF   = 19;

  localparam logic [3:0] KEY_NONE = 4'd0;
  localparam logic [3:0] KEY_B1   = 4'd1;
  localparam logic [3:0] KEY_B2   = 4'd2;
  localparam logic [3:0] KEY_B3   = 4'd3;
  localparam logic [3:0] KEY_B4   = 4'd4;
  localparam logic [3:0] KEY_B5   = 4'd5;
  localparam logic [3:0] KEY_B6   = 4'd6;
  localparam logic [3:0] KEY_B7   = 4'd7;
  localparam logic [3:0] KEY_B8   = 4'd8;
  localparam logic [3:0] KEY_B9   = 4'd9;
  localparam logic [3:0] KEY_B10  = 4'd10;
  localparam logic [3:0] KEY_B11  = 4'd11;
  localparam logic [3:0] KEY_B12  = 4'd12;

  // Bit 11 is b1, bit 0 is b12.
  function automatic logic [3:0] code_of(input int idx);
    return 4'(N_KEYS - idx);
  endfunction

endpackage

// File: rtl/button_scan_debounce_cell.sv
// button_scan_debounce_cell: one button's synchroniser + debouncer.
//   clk, rst  system clock, async active-high reset
//   pin       raw button level, asynchronous to clk
//   level     debounced level
//   rise      one-cycle pulse, high in the cycle whose closing edge takes
//             level 0->1 (combinational, so the caller can capture it on
//             the same edge that level toggles)
module button_scan_debounce_cell
  import button_scan_pkg::*;
#(
  parameter int DEB_CNT = DEB_CNT_DEF,  // must be >= 2
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEB_CNT - 1);

  logic             s1, s2, deb;
  logic [CNT_W-1:0] cnt;
  logic             flip;

  // Mismatch has persisted for DEB_CNT cycles including this one.
  assign flip  = (s2 != deb) && (cnt == LAST);
  assign rise  = flip && !deb;
  assign level = deb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      deb <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= pin;
      s2 <= s1;
      if (s2 == deb) begin
        cnt <= '0;
      end else if (flip) begin
        deb <= ~deb;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/button_scan.sv
// button_scan: 12-button front-end. Debounces each button, captures rising
// presses in a pending mask and emits them one per cycle, b1 first.
//   clk, rst   system clock, async active-high reset
//   keypad_in  raw buttons {b1..b12} (bit 11 = b1), active-high, async
//   scan_out   key code of the emitted press (1..12), 0 when idle
//   valid      one-cycle strobe, high exactly when scan_out != 0
//   held       debounced level per button, same bit order as keypad_in
module button_scan
  import button_scan_pkg::*;
#(
  parameter int DEB_CNT = DEB_CNT_DEF,  // must be >= 2
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] keypad_in,
  output logic [3:0]        scan_out,
  output logic              valid,
  output logic [N_KEYS-1:0] held
);

  logic [N_KEYS-1:0] rise;
  logic [N_KEYS-1:0] pending;
  logic [N_KEYS-1:0] sel_mask;
  logic [3:0]        sel_code;

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    button_scan_debounce_cell #(
      .DEB_CNT (DEB_CNT),
      .CNT_W   (CNT_W)
    ) u_cell (
      .clk   (clk),
      .rst   (rst),
      .pin   (keypad_in[k]),
      .level (held[k]),
      .rise  (rise[k])
    );
  end

  // Highest set bit index has the lowest code, so scan upward and let the
  // last hit win.
  always_comb begin
    sel_code = KEY_NONE;
    sel_mask = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      if (pending[i]) begin
        sel_code = code_of(i);
        sel_mask = N_KEYS'(1) << i;
      end
    end
  end

  // Clear before set: a new rise on the bit being emitted survives and
  // produces a second event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending  <= '0;
      scan_out <= KEY_NONE;
      valid    <= 1'b0;
    end else begin
      pending  <= (pending & ~sel_mask) | rise;
      scan_out <= sel_code;
      valid    <= (sel_code != KEY_NONE);
    end
  end

endmodule
